// File: rtl/input_debounce_sync_pkg.sv
// Shared definitions for the input debounce/synchronizer block: FSM state
// encodings and a ceil(log2) helper used to size the qualification counter.
package input_debounce_sync_pkg;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } dbnc_state_e;

  // Smallest width that can hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/input_debounce_sync_sync_chain.sv
// Plain flop chain that brings an asynchronous input into the clk domain.
// Nothing sits between the flops so each stage has a full cycle to settle.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw input through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/input_debounce_sync.sv
// Synchronizes a raw button/switch input, debounces it with a counter FSM and
// produces a clean level, one-cycle edge pulses, a busy flag and a saturating
// count of rejected transitions.
module input_debounce_sync
  import input_debounce_sync_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  output logic                clean_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                syncS;
  dbnc_state_e         state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                clean_q;
  logic                rise_q;
  logic                fall_q;
  logic                busy_q;
  logic [GLITCH_W-1:0] glitch_q;
  logic [GLITCH_W-1:0] glitch_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(raw_in),
    .q_o(syncS)
  );

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_q != GLITCH_MAX) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  // Debounce FSM; every output is registered alongside the state so nothing
  // combinational reaches the ports from raw_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (syncS) begin
            state_q <= S_WAIT_H;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_WAIT_H: begin
          if (!syncS) begin
            state_q  <= S_LOW;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            glitch_q <= glitch_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            clean_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (!syncS) begin
            state_q <= S_WAIT_L;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_WAIT_L: begin
          if (syncS) begin
            state_q  <= S_HIGH;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            glitch_q <= glitch_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            clean_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debounce_sync.sv
// Self-checking bench for input_debounce_sync: directed latency/glitch/reset
// scenarios followed by random raw_in runs, all compared against a run-length
// model of the debounce rules.
module tb_input_debounce_sync;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int GW   = 8;
  localparam int GMAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          raw_in;
  logic          clean_out;
  logic          rise_pulse;
  logic          fall_pulse;
  logic          busy;
  logic [GW-1:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: raw history delay line, accepted level and the
  // length of the current run of samples that disagree with it.
  int hist [SYNC];
  int modelClean;
  int modelRise;
  int modelFall;
  int modelBusy;
  int modelGlitch;
  int runLen;

  input_debounce_sync #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .GLITCH_W(GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_in(raw_in),
    .clean_out(clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy(busy),
    .glitch_cnt(glitch_cnt)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Advance the model by one rising edge using the current rst/raw_in.
  task automatic modelEdge();
    int sVal;
    modelRise = 0;
    modelFall = 0;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 0;
      modelClean  = 0;
      modelGlitch = 0;
      runLen      = 0;
    end else begin
      sVal = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(raw_in);
      if (sVal != modelClean) begin
        runLen = runLen + 1;
        if (runLen == DEB + 1) begin
          modelClean = sVal;
          modelRise  = sVal;
          modelFall  = 1 - sVal;
          runLen     = 0;
        end
      end else if (runLen > 0) begin
        if (modelGlitch < GMAX) modelGlitch = modelGlitch + 1;
        runLen = 0;
      end
    end
    modelBusy = (runLen > 0) ? 1 : 0;
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".clean"},  int'(clean_out),  modelClean);
    checkValue({tag, ".rise"},   int'(rise_pulse), modelRise);
    checkValue({tag, ".fall"},   int'(fall_pulse), modelFall);
    checkValue({tag, ".busy"},   int'(busy),       modelBusy);
    checkValue({tag, ".glitch"}, int'(glitch_cnt), modelGlitch);
    checkValue({tag, ".excl"},   int'(rise_pulse & fall_pulse), 0);
  endtask

  // Drive inputs away from the active edge, clock once, then compare.
  task automatic applyStimulus(input logic rawVal, input logic rstVal, input string tag);
    @(negedge clk);
    raw_in = rawVal;
    rst    = rstVal;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic holdRaw(input logic rawVal, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(rawVal, 1'b0, tag);
  endtask

  int busyCycles;
  int cleanSeen;
  int level;
  int runTarget;

  initial begin
    rst    = 1'b1;
    raw_in = 1'b1;

    $display("[TB] test 1: reset with raw_in high, then release");
    applyStimulus(1'b1, 1'b1, "rst0");
    applyStimulus(1'b1, 1'b1, "rst1");
    checkValue("rst.clean", int'(clean_out), 0);
    checkValue("rst.glitch", int'(glitch_cnt), 0);
    busyCycles = 0;
    for (int k = 1; k <= 25; k++) begin
      applyStimulus(1'b1, 1'b0, "t1");
      checkValue("t1.latClean", int'(clean_out), (k >= 19) ? 1 : 0);
      checkValue("t1.latRise", int'(rise_pulse), (k == 19) ? 1 : 0);
      busyCycles += int'(busy);
    end
    checkValue("t1.busyCycles", busyCycles, DEB);

    $display("[TB] test 2: stable low gives fall 19 edges later");
    for (int k = 1; k <= 25; k++) begin
      applyStimulus(1'b0, 1'b0, "t2");
      checkValue("t2.latFall", int'(fall_pulse), (k == 19) ? 1 : 0);
    end

    $display("[TB] test 3: 16-cycle pulse rejected, 17-cycle pulse accepted");
    holdRaw(1'b1, 16, "t3a");
    holdRaw(1'b0, 25, "t3a");
    checkValue("t3.rejectGlitch", int'(glitch_cnt), 1);
    checkValue("t3.rejectClean", int'(clean_out), 0);
    for (int k = 1; k <= 50; k++) begin
      applyStimulus((k <= 17) ? 1'b1 : 1'b0, 1'b0, "t3b");
      checkValue("t3.acceptClean", int'(clean_out), (k >= 19 && k < 36) ? 1 : 0);
    end

    $display("[TB] test 4: bounce during fall qualification");
    holdRaw(1'b1, 25, "t4pre");
    for (int k = 1; k <= 35; k++) begin
      applyStimulus((k >= 6 && k <= 8) ? 1'b1 : 1'b0, 1'b0, "t4");
      checkValue("t4.latFall", int'(fall_pulse), (k == 27) ? 1 : 0);
    end
    checkValue("t4.glitch", int'(glitch_cnt), 2);

    $display("[TB] test 5: 300 short glitches saturate the counter");
    cleanSeen = 0;
    for (int g = 0; g < 300; g++) begin
      holdRaw(1'b1, 2, "t5");
      holdRaw(1'b0, 2, "t5");
      cleanSeen |= int'(clean_out);
    end
    holdRaw(1'b0, 6, "t5");
    checkValue("t5.saturated", int'(glitch_cnt), GMAX);
    checkValue("t5.noToggle", cleanSeen, 0);

    $display("[TB] test 6: reset during WAIT_H and during HIGH");
    holdRaw(1'b1, 8, "t6a");
    checkValue("t6.busyBefore", int'(busy), 1);
    applyStimulus(1'b1, 1'b1, "t6rstWait");
    checkValue("t6.waitBusy", int'(busy), 0);
    checkValue("t6.waitGlitch", int'(glitch_cnt), 0);
    holdRaw(1'b1, 25, "t6b");
    checkValue("t6.highBefore", int'(clean_out), 1);
    applyStimulus(1'b1, 1'b1, "t6rstHigh");
    checkValue("t6.highClean", int'(clean_out), 0);
    checkValue("t6.highNoFall", int'(fall_pulse), 0);
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(1'b1, 1'b0, "t6c");
      checkValue("t6.requal", int'(rise_pulse), (k == 19) ? 1 : 0);
    end

    $display("[TB] random phase");
    level = 0;
    for (int seg = 0; seg < 120; seg++) begin
      level     = 1 - level;
      runTarget = $urandom_range(1, 24);
      for (int i = 0; i < runTarget; i++) begin
        applyStimulus(level[0], ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
